// File: rtl/reg_bank_wb.sv
// ----------------------------------------------------------------------------
// reg_bank_wb
//   General-purpose register bank for the multicycle datapath (2**ADDR_W x
//   DATA_W). The write-register select mux upstream delivers its destination
//   address one clock after the write-back request. The bank therefore parks
//   the write data in a one-entry pending stage and commits it on the next
//   edge, when the matching address arrives.
//
//   Two registered read ports (rs, rt) forward the committing write, so a read
//   issued on the commit edge returns the new value. Register 0 always reads 0
//   and ignores writes. Register 29 ($sp) resets to SP_RESET.
//
// Ports
//   clk           in   1       system clock, rising edge
//   reset_n       in   1       asynchronous active-low reset
//   reg_dst_addr  in   ADDR_W  destination address, valid one cycle after wb_en
//   wb_en         in   1       write-back request, sampled together with wb_data
//   wb_data       in   DATA_W  write-back value
//   rs_addr       in   ADDR_W  read port A address
//   rt_addr       in   ADDR_W  read port B address
//   rs_data       out  DATA_W  read port A data (registered)
//   rt_data       out  DATA_W  read port B data (registered)
//   wb_pending    out  1       pending stage holds an uncommitted write
// ----------------------------------------------------------------------------
module reg_bank_wb #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] reg_dst_addr,
    input  logic              wb_en,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              wb_pending
);

    localparam int                NREG   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(29);

    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_pend_valid;
    logic [DATA_W-1:0] r_pend_data;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;

    logic              w_commit;
    logic [DATA_W-1:0] w_rs_next;
    logic [DATA_W-1:0] w_rt_next;

    // A commit to r0 is discarded, but the pending stage still drains.
    assign w_commit = r_pend_valid && (reg_dst_addr != '0);

    // ------------------------------------------------------------------------
    // Pending stage: captures the write-back request, one edge ahead of commit.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would let one block see another's update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
        end else begin
            r_pend_valid <= wb_en;
            if (wb_en) begin
                r_pend_data <= wb_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Register array. Commit uses reg_dst_addr as sampled on the commit edge.
    // ------------------------------------------------------------------------
    // NOTE: the array is built from resettable flops rather than a RAM macro,
    // because a reset has to restore every register (and $sp) at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[SP_IDX] <= SP_RESET;
        end else if (w_commit) begin
            r_regs[reg_dst_addr] <= r_pend_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read-port next values. The array still holds the pre-commit value at
    // this edge, so a read of the committing address takes the pending data
    // instead. Address 0 wins over forwarding.
    // ------------------------------------------------------------------------
    // NOTE: every output of always_comb is given a default first; an
    // unassigned path would otherwise infer a latch.
    always_comb begin
        w_rs_next = '0;
        w_rt_next = '0;
        if (rs_addr != '0) begin
            if (r_pend_valid && (rs_addr == reg_dst_addr)) begin
                w_rs_next = r_pend_data;
            end else begin
                w_rs_next = r_regs[rs_addr];
            end
        end
        if (rt_addr != '0) begin
            if (r_pend_valid && (rt_addr == reg_dst_addr)) begin
                w_rt_next = r_pend_data;
            end else begin
                w_rt_next = r_regs[rt_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
        end else begin
            r_rs_data <= w_rs_next;
            r_rt_data <= w_rt_next;
        end
    end

    assign rs_data    = r_rs_data;
    assign rt_data    = r_rt_data;
    assign wb_pending = r_pend_valid;

endmodule
